// File: rtl/banco_registros_param.sv
// Parameterised register file with N_READ combinational read ports, one write port,
// optional write-to-read forwarding and a per-register busy scoreboard with live count.
module banco_registros_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_READ = 2,
    parameter int BYPASS = 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_READ*ADDR_W-1:0] readReg,
    output logic [N_READ*DATA_W-1:0] readData,
    output logic [N_READ-1:0]        readBusy,
    input  logic [ADDR_W-1:0]        writeReg,
    input  logic [DATA_W-1:0]        writeData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        issueReg,
    input  logic                     issueValid,
    output logic [ADDR_W:0]          busyCount
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_next;
    logic [ADDR_W:0]   r_busy_count;
    logic              w_wr_en;
    logic              w_iss_en;
    logic              w_inc;
    logic              w_dec;

    // Reset suppresses the write entirely, including forwarding to the read ports.
    assign w_wr_en  = RegWrite && (writeReg != '0) && !RESET;
    assign w_iss_en = issueValid && (issueReg != '0);

    // Count tracks actual bit transitions; a same-index issue+write leaves the bit set.
    assign w_inc = w_iss_en && !r_busy[issueReg];
    assign w_dec = w_wr_en && r_busy[writeReg] && !(w_iss_en && (issueReg == writeReg));

    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_en) begin
            w_busy_next[writeReg] = 1'b0;
        end
        if (w_iss_en) begin
            w_busy_next[issueReg] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_regs[k] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_en) begin
                r_regs[writeReg] <= writeData;
            end
            r_busy       <= w_busy_next;
            r_busy_count <= r_busy_count + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);
        end
    end

    assign busyCount = r_busy_count;

    for (genvar g = 0; g < N_READ; g++) begin : g_rd
        logic [ADDR_W-1:0] w_idx;
        logic              w_hit;
        logic [DATA_W-1:0] w_stored;

        assign w_idx    = readReg[g*ADDR_W +: ADDR_W];
        assign w_hit    = (BYPASS != 0) && w_wr_en && (writeReg == w_idx);
        assign w_stored = (w_idx == '0) ? '0 : r_regs[w_idx];

        assign readData[g*DATA_W +: DATA_W] = w_hit ? writeData : w_stored;
        assign readBusy[g]                  = w_hit ? 1'b0 : r_busy[w_idx];
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: a forwarding 2-port instance and a non-forwarding
// 4-port instance share write/issue/reset; a reference model feeds a scoreboard queue.
module tb_banco_registros_param;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         RegWrite;
    logic         issueValid;
    logic [4:0]   writeReg;
    logic [4:0]   issueReg;
    logic [31:0]  writeData;
    logic [9:0]   rd_a;
    logic [19:0]  rd_b;
    logic [63:0]  rdata_a;
    logic [1:0]   rbusy_a;
    logic [5:0]   cnt_a;
    logic [127:0] rdata_b;
    logic [3:0]   rbusy_b;
    logic [5:0]   cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    banco_registros_param #(.DATA_W(32), .ADDR_W(5), .N_READ(2), .BYPASS(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .readReg(rd_a), .readData(rdata_a), .readBusy(rbusy_a),
        .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite),
        .issueReg(issueReg), .issueValid(issueValid), .busyCount(cnt_a)
    );

    banco_registros_param #(.DATA_W(32), .ADDR_W(5), .N_READ(4), .BYPASS(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .readReg(rd_b), .readData(rdata_b), .readBusy(rbusy_b),
        .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite),
        .issueReg(issueReg), .issueValid(issueValid), .busyCount(cnt_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] r, input bit byp);
        if (r == 5'd0) return 32'h0;
        if (byp && RegWrite && !RESET && writeReg == r) return writeData;
        return m_regs[r];
    endfunction

    function automatic logic exp_bz(input logic [4:0] r, input bit byp);
        if (byp && RegWrite && !RESET && writeReg != 5'd0 && writeReg == r) return 1'b0;
        return m_busy[r];
    endfunction

    function automatic logic [31:0] popcnt();
        logic [31:0] c = 0;
        for (int i = 1; i < 32; i++) c += {31'd0, m_busy[i]};
        return c;
    endfunction

    task automatic push_expected();
        exp_t e;
        logic [31:0] bz;
        for (int p = 0; p < 2; p++) begin
            e.tag = $sformatf("a_data%0d", p);
            e.v = exp_rd(rd_a[p*5 +: 5], 1'b1);
            sb.push_back(e);
        end
        bz = 0;
        for (int p = 0; p < 2; p++) bz[p] = exp_bz(rd_a[p*5 +: 5], 1'b1);
        e.tag = "a_busy"; e.v = bz; sb.push_back(e);
        e.tag = "a_cnt"; e.v = popcnt(); sb.push_back(e);
        for (int p = 0; p < 4; p++) begin
            e.tag = $sformatf("b_data%0d", p);
            e.v = exp_rd(rd_b[p*5 +: 5], 1'b0);
            sb.push_back(e);
        end
        bz = 0;
        for (int p = 0; p < 4; p++) bz[p] = exp_bz(rd_b[p*5 +: 5], 1'b0);
        e.tag = "b_busy"; e.v = bz; sb.push_back(e);
        e.tag = "b_cnt"; e.v = popcnt(); sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty got none expected entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.v);
        end
    endtask

    task automatic compare_all();
        pop_chk(rdata_a[31:0]);
        pop_chk(rdata_a[63:32]);
        pop_chk({30'd0, rbusy_a});
        pop_chk({26'd0, cnt_a});
        for (int p = 0; p < 4; p++) pop_chk(rdata_b[p*32 +: 32]);
        pop_chk({28'd0, rbusy_b});
        pop_chk({26'd0, cnt_b});
    endtask

    task automatic model_update();
        if (RESET) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            m_busy = 0;
        end else begin
            if (RegWrite && writeReg != 5'd0) begin
                m_regs[writeReg] = writeData;
                m_busy[writeReg] = 1'b0;
            end
            if (issueValid && issueReg != 5'd0) m_busy[issueReg] = 1'b1;
        end
    endtask

    // Inputs are set just after a rising edge; this checks at the falling edge and
    // advances the model on the next rising edge.
    task automatic cycle();
        push_expected();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle();
        RESET = 0; RegWrite = 0; issueValid = 0;
        writeReg = 0; issueReg = 0; writeData = 0;
    endtask

    initial begin
        idle();
        RESET = 1;
        rd_a = 0;
        rd_b = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_busy = 0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 0;
        chk("rst_cnt", {26'd0, cnt_a}, 32'd0);
        chk("rst_busy", {30'd0, rbusy_a}, 32'd0);

        // Write to x0 is ignored
        RegWrite = 1; writeReg = 0; writeData = 32'hA1;
        cycle();
        idle();
        #1;
        chk("x0_read", rdata_a[31:0], 32'h0);
        chk("x0_cnt", {26'd0, cnt_a}, 32'd0);
        cycle();

        // Stored value visible on both ports next cycle
        RegWrite = 1; writeReg = 13; writeData = 32'hA234;
        cycle();
        idle();
        rd_a = {5'd13, 5'd13};
        #1;
        chk("x13_p0", rdata_a[31:0], 32'hA234);
        chk("x13_p1", rdata_a[63:32], 32'hA234);
        chk("x13_busy", {30'd0, rbusy_a}, 32'd0);
        cycle();

        // Forwarding vs. no forwarding
        RegWrite = 1; writeReg = 16; writeData = 32'h1234;
        rd_a = {5'd16, 5'd0};
        rd_b = {15'd0, 5'd16};
        #1;
        chk("byp1_same", rdata_a[63:32], 32'h1234);
        chk("byp0_same", rdata_b[31:0], 32'h0);
        cycle();
        idle();
        #1;
        chk("byp0_next", rdata_b[31:0], 32'h1234);
        cycle();

        // Scoreboard count sequence
        issueValid = 1; issueReg = 5;
        cycle();
        chk("sb_cnt1", {26'd0, cnt_a}, 32'd1);
        issueReg = 6;
        cycle();
        chk("sb_cnt2", {26'd0, cnt_a}, 32'd2);
        issueReg = 5;
        cycle();
        chk("sb_cnt3", {26'd0, cnt_a}, 32'd2);
        issueValid = 0; RegWrite = 1; writeReg = 6; writeData = 32'h66;
        cycle();
        chk("sb_cnt4", {26'd0, cnt_a}, 32'd1);
        issueValid = 1; issueReg = 5; writeReg = 5; writeData = 32'h55;
        cycle();
        chk("sb_cnt5", {26'd0, cnt_a}, 32'd1);
        idle();
        rd_a = {5'd6, 5'd5};
        #1;
        chk("sb_busy5", {30'd0, rbusy_a}, 32'd1);
        cycle();

        // Reset wins over a simultaneous write and clears busy state
        RegWrite = 1; writeReg = 31; writeData = 32'hFFFFFFFF;
        cycle();
        RegWrite = 0; issueValid = 1; issueReg = 31;
        cycle();
        RESET = 1; issueValid = 0; RegWrite = 1; writeReg = 31; writeData = 32'h0BAD_F00D;
        rd_a = {5'd31, 5'd31};
        cycle();
        idle();
        #1;
        chk("rst_x31", rdata_a[31:0], 32'h0);
        chk("rst_cnt2", {26'd0, cnt_a}, 32'd0);
        chk("rst_rbusy", {30'd0, rbusy_a}, 32'd0);
        cycle();

        // Four independent ports
        for (int i = 1; i <= 4; i++) begin
            RegWrite = 1; writeReg = 5'(i); writeData = 32'(i);
            cycle();
        end
        idle();
        rd_b = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        for (int p = 0; p < 4; p++) chk($sformatf("n4_p%0d", p), rdata_b[p*32 +: 32], 32'(p + 1));
        cycle();

        // Randomised traffic over a narrow index range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            RESET      = ($urandom_range(0, 59) == 0);
            RegWrite   = $urandom_range(0, 1);
            issueValid = $urandom_range(0, 1);
            writeReg   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            issueReg   = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            writeData  = $urandom;
            for (int p = 0; p < 2; p++) rd_a[p*5 +: 5] = 5'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++) rd_b[p*5 +: 5] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rd_a[4:0] = writeReg;
            if ($urandom_range(0, 3) == 0) rd_b[9:5] = writeReg;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
